// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_pkg
// Description : Shared types for the framebuffer write stage. It defines the
//               pixel address width, the FIFO entry layout and the writer
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

    localparam int FB_ADDR_W = 20;
    localparam int FB_BRI_W  = 8;

    // One queued framebuffer operation. An entry with we=0 is a frame-end
    // marker that carries only the 'last' flag.
    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [FB_BRI_W-1:0]  data;
        logic                 we;
        logic                 last;
    } fb_entry_t;

    typedef enum logic [0:0] {
        ST_RUN        = 1'b0,
        ST_WAIT_VSYNC = 1'b1
    } fb_state_e;

endpackage : fb_pkg
`default_nettype wire

// File: rtl/fb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fb_fifo
// Description : Synchronous FIFO of fb_entry_t. The head is read straight from
//               registered storage, so nothing on the push side reaches the
//               head combinationally. A push into a full FIFO is accepted
//               only when a pop happens in the same cycle.
// Ports       : clk, rst (async, active-high)
//               push_i/entry_i  - write request and data
//               pop_i           - remove head (ignored when empty)
//               head_o/empty_o  - current head entry and empty flag
//               push_ok_o       - push was accepted this cycle
//               count_next_o    - occupancy after this cycle's push/pop
// Revision    : 1.0 - initial release
// ============================================================================
module fb_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  fb_entry_t              entry_i,
    input  logic                   pop_i,
    output fb_entry_t              head_o,
    output logic                   empty_o,
    output logic                   push_ok_o,
    output logic [$clog2(DEPTH):0] count_next_o
);

    localparam int AW = $clog2(DEPTH);

    fb_entry_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          is_full;
    logic          is_empty;
    logic          pop_ok;

    assign is_full   = (count_q == (AW+1)'(DEPTH));
    assign is_empty  = (count_q == '0);
    assign pop_ok    = pop_i & ~is_empty;
    assign push_ok_o = push_i & (~is_full | pop_ok);
    assign empty_o   = is_empty;
    assign head_o    = mem_q[rd_ptr_q];

    always_comb begin
        count_next_o = count_q + {{AW{1'b0}}, push_ok_o} - {{AW{1'b0}}, pop_ok};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_o) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)    rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_next_o;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok_o) mem_q[wr_ptr_q] <= entry_i;
    end

endmodule : fb_fifo
`default_nettype wire

// File: rtl/fb_writer.sv
`default_nettype none
// ============================================================================
// Module      : fb_writer
// Description : Framebuffer write stage. It queues resolved pixels and writes
//               them to the back bank through a ready-handshaked port. At frame
//               end it waits for the next vsync before swapping banks.
// Ports       : clk, rst (async, active-high)
//               fb_addr_w, hit_w, bri_w, valid_w, swap - resolved pixel input
//               vsync                      - display timing pulse
//               mem_wready / mem_we, mem_addr, mem_wdata - write port
//               front_sel  - bank being scanned out
//               stall      - upstream must stop issuing
//               frame_done - one-cycle pulse on bank swap
//               overflow   - sticky, a push was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module fb_writer
    import fb_pkg::*;
#(
    parameter int          ADDR_W     = FB_ADDR_W,
    parameter int          FIFO_DEPTH = 8,
    parameter int          SKID       = 4,
    parameter logic [7:0]  BG_BRI     = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] fb_addr_w,
    input  logic              hit_w,
    input  logic [7:0]        bri_w,
    input  logic              valid_w,
    input  logic              swap,
    input  logic              vsync,
    input  logic              mem_wready,
    output logic              mem_we,
    output logic [ADDR_W:0]   mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              front_sel,
    output logic              stall,
    output logic              frame_done,
    output logic              overflow
);

    localparam int             CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]  STALL_TH  = CW'(FIFO_DEPTH - SKID);

    fb_state_e     state_q, state_d;
    logic          front_sel_q, front_sel_d;
    logic          armed_q, armed_d;
    logic          frame_done_q, frame_done_d;
    logic          stall_q, stall_d;
    logic          overflow_q, overflow_d;

    logic          push;
    logic          pop;
    logic          push_ok;
    logic          fifo_empty;
    fb_entry_t     entry_in;
    fb_entry_t     head;
    logic [CW-1:0] count_next;

    assign push          = valid_w | swap;
    assign entry_in.addr = fb_addr_w;
    assign entry_in.data = hit_w ? bri_w : BG_BRI;
    assign entry_in.we   = valid_w;
    assign entry_in.last = swap;

    fb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .entry_i      (entry_in),
        .pop_i        (pop),
        .head_o       (head),
        .empty_o      (fifo_empty),
        .push_ok_o    (push_ok),
        .count_next_o (count_next)
    );

    always_comb begin
        state_d      = state_q;
        front_sel_d  = front_sel_q;
        armed_d      = 1'b0;
        frame_done_d = 1'b0;
        pop          = 1'b0;
        mem_we       = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (!fifo_empty) begin
                    if (head.we) begin
                        mem_we = 1'b1;
                        pop    = mem_wready;
                    end else begin
                        // Frame-end marker: nothing to write, retire it now.
                        pop = 1'b1;
                    end
                    if (pop && head.last) state_d = ST_WAIT_VSYNC;
                end
            end
            ST_WAIT_VSYNC: begin
                // armed_q is low in the first WAIT cycle so a vsync there
                // is not taken as the swap point.
                armed_d = 1'b1;
                if (armed_q && vsync) begin
                    state_d      = ST_RUN;
                    front_sel_d  = ~front_sel_q;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
        // Registered from next-cycle values, so stall lines up with the
        // state and occupancy it describes.
        stall_d    = (state_d == ST_WAIT_VSYNC) || (count_next >= STALL_TH);
        overflow_d = overflow_q | (push & ~push_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            front_sel_q  <= 1'b0;
            armed_q      <= 1'b0;
            frame_done_q <= 1'b0;
            stall_q      <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            front_sel_q  <= front_sel_d;
            armed_q      <= armed_d;
            frame_done_q <= frame_done_d;
            stall_q      <= stall_d;
            overflow_q   <= overflow_d;
        end
    end

    // The bank is chosen at pop time, so pixels queued during WAIT_VSYNC
    // land in the bank that becomes the back bank after the swap.
    assign mem_addr   = {~front_sel_q, head.addr};
    assign mem_wdata  = head.data;
    assign front_sel  = front_sel_q;
    assign stall      = stall_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule : fb_writer
`default_nettype wire

// File: tb/tb_fb_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_writer
// Description : Self-checking bench for fb_writer. Directed vector table for
//               single pixel writes plus sequences for backpressure, bank
//               swap, marker frames, overflow and mid-run reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] fb_addr_w;
    logic        hit_w;
    logic [7:0]  bri_w;
    logic        valid_w;
    logic        swap;
    logic        vsync;
    logic        mem_wready;
    logic        mem_we;
    logic [20:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        front_sel;
    logic        stall;
    logic        frame_done;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    fb_writer dut (
        .clk        (clk),
        .rst        (rst),
        .fb_addr_w  (fb_addr_w),
        .hit_w      (hit_w),
        .bri_w      (bri_w),
        .valid_w    (valid_w),
        .swap       (swap),
        .vsync      (vsync),
        .mem_wready (mem_wready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .front_sel  (front_sel),
        .stall      (stall),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] addr;
        logic        hit;
        logic [7:0]  bri;
        logic [20:0] exp_addr;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pix(input logic v, input logic [19:0] a, input logic h,
                             input logic [7:0] b, input logic s);
        valid_w   = v;
        fb_addr_w = a;
        hit_w     = h;
        bri_w     = b;
        swap      = s;
    endtask

    task automatic idle_in();
        drive_pix(1'b0, 20'd0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        vecs[0] = '{20'd5,     1'b1, 8'hA0, 21'h100005, 8'hA0};
        vecs[1] = '{20'd7,     1'b0, 8'hFF, 21'h100007, 8'h00};
        vecs[2] = '{20'hFFFFF, 1'b1, 8'hFF, 21'h1FFFFF, 8'hFF};
        vecs[3] = '{20'd0,     1'b1, 8'h01, 21'h100000, 8'h01};
        vecs[4] = '{20'h12345, 1'b0, 8'h55, 21'h112345, 8'h00};

        rst = 1'b1;
        idle_in();
        vsync      = 1'b0;
        mem_wready = 1'b1;
        #2;
        chk("rst_mem_we",     32'(mem_we),     32'd0);
        chk("rst_front_sel",  32'(front_sel),  32'd0);
        chk("rst_stall",      32'(stall),      32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_overflow",   32'(overflow),   32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // Single pixel writes: visible the cycle after push, popped next.
        for (int i = 0; i < 5; i++) begin
            drive_pix(1'b1, vecs[i].addr, vecs[i].hit, vecs[i].bri, 1'b0);
            step();
            idle_in();
            chk("vec_we",    32'(mem_we),    32'd1);
            chk("vec_addr",  32'(mem_addr),  32'(vecs[i].exp_addr));
            chk("vec_wdata", 32'(mem_wdata), 32'(vecs[i].exp_data));
            step();
            chk("vec_empty", 32'(mem_we),    32'd0);
        end

        // Backpressure: 3 queued entries held for 5 cycles, then drained.
        mem_wready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_pix(1'b1, 20'(10 + i), 1'b1, 8'(1 + i), 1'b0);
            step();
        end
        idle_in();
        for (int i = 0; i < 5; i++) begin
            chk("hold_we",    32'(mem_we),    32'd1);
            chk("hold_addr",  32'(mem_addr),  32'h10000A);
            chk("hold_wdata", 32'(mem_wdata), 32'h01);
            step();
        end
        mem_wready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("drain_we",    32'(mem_we),    32'd1);
            chk("drain_addr",  32'(mem_addr),  32'h100000 + 32'(10 + i));
            chk("drain_wdata", 32'(mem_wdata), 32'(1 + i));
            step();
        end
        chk("drain_empty", 32'(mem_we), 32'd0);

        // Frame end on a pixel, then pixels of the next frame during the wait.
        drive_pix(1'b1, 20'd30, 1'b1, 8'h77, 1'b1);
        step();
        idle_in();
        chk("last_we",   32'(mem_we),   32'd1);
        chk("last_addr", 32'(mem_addr), 32'h10001E);
        step();
        chk("wait_stall",  32'(stall),     32'd1);
        chk("wait_front",  32'(front_sel), 32'd0);
        chk("wait_we",     32'(mem_we),    32'd0);
        for (int i = 0; i < 3; i++) begin
            drive_pix(1'b1, 20'(40 + i), 1'b1, 8'(8'h40 + i), 1'b0);
            step();
            idle_in();
            chk("wait_no_we", 32'(mem_we), 32'd0);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            chk("wait_no_we2", 32'(mem_we),    32'd0);
            chk("wait_stall2", 32'(stall),     32'd1);
        end
        vsync = 1'b1;
        step();
        vsync = 1'b0;
        chk("swap_front", 32'(front_sel),  32'd1);
        chk("swap_done",  32'(frame_done), 32'd1);
        chk("swap_stall", 32'(stall),      32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("nf_we",    32'(mem_we),    32'd1);
            chk("nf_addr",  32'(mem_addr),  32'(40 + i));
            chk("nf_wdata", 32'(mem_wdata), 32'(8'h40 + i));
            step();
            chk("nf_done_low", 32'(frame_done), 32'd0);
        end
        chk("nf_empty", 32'(mem_we), 32'd0);

        // vsync while running is ignored.
        vsync = 1'b1;
        step();
        vsync = 1'b0;
        chk("run_vsync_front", 32'(front_sel),  32'd1);
        chk("run_vsync_done",  32'(frame_done), 32'd0);

        // Marker-only frame end: no write, still swaps on vsync.
        drive_pix(1'b0, 20'd0, 1'b0, 8'h00, 1'b1);
        step();
        idle_in();
        chk("marker_no_we", 32'(mem_we), 32'd0);
        step();
        chk("marker_stall", 32'(stall), 32'd1);
        step();
        step();
        vsync = 1'b1;
        step();
        vsync = 1'b0;
        chk("marker_front", 32'(front_sel),  32'd0);
        chk("marker_done",  32'(frame_done), 32'd1);
        chk("marker_stall2", 32'(stall),     32'd0);

        // Overflow: 9 pushes with the write port blocked.
        mem_wready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            drive_pix(1'b1, 20'(100 + k), 1'b1, 8'(k), 1'b0);
            step();
            chk("ovf_stall",    32'(stall),    (k >= 4) ? 32'd1 : 32'd0);
            chk("ovf_overflow", 32'(overflow), (k >= 9) ? 32'd1 : 32'd0);
        end
        idle_in();
        chk("ovf_head_addr", 32'(mem_addr), 32'h100065);
        step();
        step();
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Asynchronous reset in mid-operation.
        rst = 1'b1;
        #1;
        chk("mrst_overflow", 32'(overflow),  32'd0);
        chk("mrst_we",       32'(mem_we),    32'd0);
        chk("mrst_stall",    32'(stall),     32'd0);
        chk("mrst_front",    32'(front_sel), 32'd0);
        step();
        rst = 1'b0;
        mem_wready = 1'b1;
        step();
        chk("post_rst_empty", 32'(mem_we), 32'd0);
        drive_pix(1'b1, 20'd3, 1'b1, 8'hC3, 1'b0);
        step();
        idle_in();
        chk("post_rst_we",   32'(mem_we),   32'd1);
        chk("post_rst_addr", 32'(mem_addr), 32'h100003);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fb_writer
`default_nettype wire

// File: doc/fb_writer.md
Name: fb_writer

Overview:
- Framebuffer write stage directly downstream of the per-pixel depth-reduce stage.
- Consumes each resolved pixel (address, hit, brightness, valid) and the frame-end swap flag.
- Buffers pixels in a small FIFO and writes them to the back bank of a double-buffered framebuffer through a ready-handshaked write port.
- At frame end it defers the bank swap to the next display vsync, which prevents tearing, and applies backpressure to the rasteriser sequencer.

Parameters:
- ADDR_W, 20, pixel address width within one bank
- FIFO_DEPTH, 8, entries in the write FIFO (power of two, >= 4)
- SKID, 4, cycles from stall assertion until upstream stops issuing valid/swap
- BG_BRI, 8'h00, brightness written for pixels with no hit

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- fb_addr_w  in  ADDR_W  pixel address of resolved pixel
- hit_w  in  1  pixel covered by some triangle
- bri_w  in  8  resolved brightness, meaningful when hit_w
- valid_w  in  1  resolved pixel present this cycle
- swap  in  1  frame end; last pixel of frame (may coincide with valid_w)
- vsync  in  1  one-cycle pulse from display timing
- mem_wready  in  1  framebuffer write port accepts this cycle
- mem_we  out  1  write request
- mem_addr  out  ADDR_W+1  {back bank bit, pixel address}
- mem_wdata  out  8  brightness to write
- front_sel  out  1  bank currently scanned out
- stall  out  1  upstream must stop issuing pixels
- frame_done  out  1  one-cycle pulse when banks swap
- overflow  out  1  sticky: push attempted into full FIFO

Behaviour:
- Reset: asynchronous, active-high. FIFO empty; state RUN; front_sel=0; mem_we=0; stall=0; frame_done=0; overflow=0.
- FIFO entry fields: {addr, data, we, last}.
- Push condition: valid_w | swap.
  - data = hit_w ? bri_w : BG_BRI.
  - we = valid_w.
  - last = swap.
  - swap with valid_w=0 pushes a marker entry (we=0, last=1).
- Full FIFO: a push is accepted when count < FIFO_DEPTH, or when a pop happens in the same cycle. Otherwise the entry is dropped and overflow sets. overflow clears only on rst.
- Latency: an entry pushed in cycle N can drive mem_we at the earliest in N+1. The FIFO head is registered, with no combinational path from inputs to mem_*.
- RUN state:
  - If the head has we=1: mem_we=1, mem_addr={~front_sel, head.addr}, mem_wdata=head.data.
  - The head pops on mem_we & mem_wready. mem_addr/mem_wdata are held stable while mem_we=1 and mem_wready=0.
  - If the head has we=0 (marker): it pops the next cycle without a handshake, and mem_we=0.
  - Popping any entry with last=1 moves the state to WAIT_VSYNC.
- WAIT_VSYNC state:
  - No pops; mem_we=0. Entries keep being pushed; they belong to the next frame.
  - The first vsync strictly after entering WAIT_VSYNC toggles front_sel, pulses frame_done for one cycle, and returns to RUN.
  - A vsync in the entry cycle does not count. vsync in RUN is ignored.
- State machine: RUN -> WAIT_VSYNC on pop of last; WAIT_VSYNC -> RUN on vsync. No other transitions.
- stall = (state == WAIT_VSYNC) | (count >= FIFO_DEPTH - SKID), registered. Upstream may still push up to SKID entries after stall rises; overflow must not occur under that contract.
- Back bank is always ~front_sel. The bank for an entry is evaluated at pop time, so entries pushed after swap are written to the new back bank.
- rst mid-operation discards FIFO contents and pending swap, and returns front_sel to 0.

Decomposition:
- Shared package fb_pkg: FB_ADDR_W = 20, fb_entry_t struct {addr, data, we, last}, state enum {RUN, WAIT_VSYNC}.
- One sub-module: fb_fifo (synchronous FIFO with count, full/empty, same-cycle push/pop on full allowed).
- FSM, bank select, and mem-port muxing stay in fb_writer.

Test Plan:
- Reset, then push addr=5, hit=1, bri=8'hA0 with mem_wready=1 -> next cycle mem_we=1, mem_addr={1'b1,20'd5}, mem_wdata=8'hA0; FIFO empty after.
- Push addr=7, hit=0, bri=8'hFF -> mem_wdata=BG_BRI (8'h00).
- Hold mem_wready=0 for 5 cycles with 3 entries queued -> mem_addr/mem_wdata stable; entries written in order once ready rises; no loss.
- Last pixel with swap=1, vsync pulses 10 cycles later -> stall=1 after the last write; front_sel 0->1 and frame_done pulse in the cycle after vsync; stall drops.
- 3 pixels pushed during WAIT_VSYNC -> no mem_we until swap; then written with bank bit = 0 (new back bank).
- With mem_wready=0, push FIFO_DEPTH+1 entries ignoring stall -> stall rises at count 4, overflow=1 after the 9th push, and overflow remains set until rst.
